// File: rtl/tree_rsp_collector.sv
// Responder-side tree node: fans one parent request out to NUM_CHILD children and
// returns one aggregated response. Optional watchdog enabled by TREE_RSP_TIMEOUT_EN.
module tree_rsp_collector #(
  parameter int unsigned NUM_CHILD   = 5,
  parameter int unsigned TAG_W       = 4,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [TAG_W-1:0]     req_tag,
  output logic [NUM_CHILD-1:0] child_req_valid,
  input  logic [NUM_CHILD-1:0] child_req_ready,
  output logic [TAG_W-1:0]     child_req_tag,
  input  logic [NUM_CHILD-1:0] child_rsp_valid,
  output logic [NUM_CHILD-1:0] child_rsp_ready,
  input  logic [NUM_CHILD-1:0] child_rsp_err,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [TAG_W-1:0]     rsp_tag,
  output logic [NUM_CHILD-1:0] rsp_err_mask,
  output logic                 rsp_timeout
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_RESP
  } state_e;

  state_e               state_q, state_d;
  logic [TAG_W-1:0]     tag_q, tag_d;
  logic [NUM_CHILD-1:0] sent_q, sent_d;
  logic [NUM_CHILD-1:0] done_q, done_d;
  logic [NUM_CHILD-1:0] err_q, err_d;
  logic [NUM_CHILD-1:0] req_hs, rsp_hs;

`ifdef TREE_RSP_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
`endif

  always_comb begin
    state_d         = state_q;
    tag_d           = tag_q;
    sent_d          = sent_q;
    done_d          = done_q;
    err_d           = err_q;
    req_ready       = 1'b0;
    child_req_valid = '0;
    child_rsp_ready = '0;
    rsp_valid       = 1'b0;
    req_hs          = '0;
    rsp_hs          = '0;
`ifdef TREE_RSP_TIMEOUT_EN
    cnt_d           = cnt_q;
    timeout_d       = timeout_q;
`endif

    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          tag_d   = req_tag;
          sent_d  = '0;
          done_d  = '0;
          err_d   = '0;
          state_d = ST_ACTIVE;
`ifdef TREE_RSP_TIMEOUT_EN
          cnt_d     = '0;
          timeout_d = 1'b0;
`endif
        end
      end

      ST_ACTIVE: begin
        // Response readiness uses registered masks, so a child's request and
        // response can never handshake in the same cycle.
        child_req_valid = ~sent_q;
        child_rsp_ready = sent_q & ~done_q;
        req_hs          = ~sent_q & child_req_ready;
        rsp_hs          = sent_q & ~done_q & child_rsp_valid;
        sent_d          = sent_q | req_hs;
        done_d          = done_q | rsp_hs;
        err_d           = err_q | (rsp_hs & child_rsp_err);
`ifdef TREE_RSP_TIMEOUT_EN
        cnt_d = cnt_q + CNT_W'(1);
`endif
        if (&done_d) begin
          state_d = ST_RESP;
        end
`ifdef TREE_RSP_TIMEOUT_EN
        else if (cnt_q == CNT_LIMIT) begin
          state_d   = ST_RESP;
          timeout_d = 1'b1;
          err_d     = err_d | ~done_d;
        end
`endif
      end

      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      tag_q   <= '0;
      sent_q  <= '0;
      done_q  <= '0;
      err_q   <= '0;
`ifdef TREE_RSP_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      sent_q  <= sent_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef TREE_RSP_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign child_req_tag = tag_q;
  assign rsp_tag       = tag_q;
  assign rsp_err_mask  = err_q;
`ifdef TREE_RSP_TIMEOUT_EN
  assign rsp_timeout   = timeout_q;
`else
  assign rsp_timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_tree_rsp_collector.sv
// Directed self-checking bench for tree_rsp_collector (NUM_CHILD=5, TAG_W=4).
module tb_tree_rsp_collector;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_tag;
  logic [4:0] child_req_valid;
  logic [4:0] child_req_ready;
  logic [3:0] child_req_tag;
  logic [4:0] child_rsp_valid;
  logic [4:0] child_rsp_ready;
  logic [4:0] child_rsp_err;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_tag;
  logic [4:0] rsp_err_mask;
  logic       rsp_timeout;

  int checks = 0;
  int errors = 0;

  tree_rsp_collector #(
    .NUM_CHILD  (5),
    .TAG_W      (4),
    .TIMEOUT_CYC(16)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_tag        (req_tag),
    .child_req_valid(child_req_valid),
    .child_req_ready(child_req_ready),
    .child_req_tag  (child_req_tag),
    .child_rsp_valid(child_rsp_valid),
    .child_rsp_ready(child_rsp_ready),
    .child_rsp_err  (child_rsp_err),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_tag        (rsp_tag),
    .rsp_err_mask   (rsp_err_mask),
    .rsp_timeout    (rsp_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b1; req_tag = 4'h3;
    child_req_ready = '0; child_rsp_valid = '0; child_rsp_err = '0; rsp_ready = 1'b0;

    // Reset held two cycles with a pending request
    tick(); tick();
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_child_req_valid", 32'(child_req_valid), 32'h00);
    chk("rst_child_rsp_ready", 32'(child_rsp_ready), 32'h00);
    chk("rst_rsp_err_mask", 32'(rsp_err_mask), 32'h00);
    chk("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
    rst_n = 1'b1; req_valid = 1'b0;
    tick();
    chk("idle_req_ready", 32'(req_ready), 32'd1);
    chk("idle_child_req_valid", 32'(child_req_valid), 32'h00);

    // Minimum-latency transaction, tag 0xA
    req_valid = 1'b1; req_tag = 4'hA;
    child_req_ready = 5'h1F; child_rsp_valid = 5'h1F; child_rsp_err = '0;
    tick();
    req_valid = 1'b0;
    chk("c1_child_req_valid", 32'(child_req_valid), 32'h1F);
    chk("c1_child_req_tag", 32'(child_req_tag), 32'hA);
    chk("c1_req_ready", 32'(req_ready), 32'd0);
    chk("c1_child_rsp_ready", 32'(child_rsp_ready), 32'h00);
    tick();
    chk("c2_child_rsp_ready", 32'(child_rsp_ready), 32'h1F);
    chk("c2_child_req_valid", 32'(child_req_valid), 32'h00);
    chk("c2_rsp_valid", 32'(rsp_valid), 32'd0);
    tick();
    chk("c3_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("c3_rsp_tag", 32'(rsp_tag), 32'hA);
    chk("c3_rsp_err_mask", 32'(rsp_err_mask), 32'h00);
    chk("c3_rsp_timeout", 32'(rsp_timeout), 32'd0);
    chk("c3_child_rsp_ready", 32'(child_rsp_ready), 32'h00);

    // Parent back-pressure: response stays stable, new request refused
    req_valid = 1'b1; req_tag = 4'h5;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_tag", 32'(rsp_tag), 32'hA);
      chk("bp_rsp_err_mask", 32'(rsp_err_mask), 32'h00);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    req_valid = 1'b0; rsp_ready = 1'b0;
    chk("bp_done_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("bp_done_req_ready", 32'(req_ready), 32'd1);
    chk("bp_done_child_req_valid", 32'(child_req_valid), 32'h00);

    // Delayed child 1/2 requests, spurious child 1 response, child 4 error
    child_req_ready = 5'b11001; child_rsp_valid = '0; child_rsp_err = '0;
    req_valid = 1'b1; req_tag = 4'h5;
    tick();
    req_valid = 1'b0;
    chk("d1_child_req_valid", 32'(child_req_valid), 32'h1F);
    chk("d1_child_req_tag", 32'(child_req_tag), 32'h5);
    child_rsp_valid = 5'b00010; child_rsp_err = 5'b00010;
    tick();
    chk("d2_child_req_valid", 32'(child_req_valid), 32'b00110);
    chk("d2_child_rsp_ready", 32'(child_rsp_ready), 32'b11001);
    child_req_ready = 5'b11011; child_rsp_valid = 5'b10010; child_rsp_err = 5'b10010;
    tick();
    chk("d3_child_req_valid", 32'(child_req_valid), 32'b00100);
    chk("d3_child_rsp_ready", 32'(child_rsp_ready), 32'b01011);
    child_rsp_valid = 5'b01011; child_rsp_err = 5'b00000;
    tick();
    chk("d4_child_rsp_ready", 32'(child_rsp_ready), 32'b00000);
    chk("d4_rsp_valid", 32'(rsp_valid), 32'd0);
    child_rsp_valid = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("d_hold_child_req_valid", 32'(child_req_valid), 32'b00100);
      chk("d_hold_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("d_hold_child_req_tag", 32'(child_req_tag), 32'h5);
    end
    child_req_ready = 5'h1F;
    tick();
    chk("d_sent_child_req_valid", 32'(child_req_valid), 32'h00);
    chk("d_sent_child_rsp_ready", 32'(child_rsp_ready), 32'b00100);
    chk("d_sent_rsp_valid", 32'(rsp_valid), 32'd0);
    child_rsp_valid = 5'b00100;
    tick();
    child_rsp_valid = '0;
    chk("d_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("d_rsp_tag", 32'(rsp_tag), 32'h5);
    chk("d_rsp_err_mask", 32'(rsp_err_mask), 32'b10000);
    chk("d_rsp_timeout", 32'(rsp_timeout), 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("d_done_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("d_done_req_ready", 32'(req_ready), 32'd1);

`ifdef TREE_RSP_TIMEOUT_EN
    // Child 3 never responds: watchdog fires 16 cycles after entering ACTIVE
    child_req_ready = 5'h1F; child_rsp_valid = 5'b10111; child_rsp_err = '0;
    req_valid = 1'b1; req_tag = 4'hC;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("to_wait_rsp_valid", 32'(rsp_valid), 32'd0);
    end
    tick();
    chk("to_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("to_rsp_timeout", 32'(rsp_timeout), 32'd1);
    chk("to_rsp_err_mask", 32'(rsp_err_mask), 32'b01000);
    chk("to_rsp_tag", 32'(rsp_tag), 32'hC);
    chk("to_child_rsp_ready", 32'(child_rsp_ready), 32'h00);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("to_done_req_ready", 32'(req_ready), 32'd1);

    // Reset pulsed mid-ACTIVE abandons the transaction
    req_valid = 1'b1; req_tag = 4'h3;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rm_req_ready", 32'(req_ready), 32'd1);
    chk("rm_child_req_valid", 32'(child_req_valid), 32'h00);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("rm_rsp_valid", 32'(rsp_valid), 32'd0);
    end
    chk("rm_rsp_timeout", 32'(rsp_timeout), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
